// File: rtl/tdm_frame_scheduler.sv
// Schedules stereo frames from G_INPUTS I2S receivers into a single TDM stream.
// Pending words are double-buffered into a shadow bank at each frame start.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | TDM pins held low, pending stage still accepts strobes
// ST_RUN  | div/bit/slot counters sweep one frame, snapshot at slot0/bit0
module tdm_frame_scheduler #(
    parameter int G_BITS      = 16,
    parameter int G_INPUTS    = 4,
    parameter int G_SLOT_BITS = 32,
    parameter int G_MCLK_DIV  = 4
) (
    input  logic                         in_mclk,
    input  logic                         in_reset_n,
    input  logic                         in_enable,
    input  logic [G_INPUTS*G_BITS-1:0]   in_frame_left,
    input  logic [G_INPUTS*G_BITS-1:0]   in_frame_right,
    input  logic [G_INPUTS-1:0]          in_frame_strobe,
    input  logic                         in_clear_status,
    output logic                         out_bclk,
    output logic                         out_fsync,
    output logic                         out_dout,
    output logic                         out_frame_start,
    output logic [G_INPUTS-1:0]          out_stale,
    output logic                         out_active
);

    localparam int SLOT_N = 2 * G_INPUTS;
    localparam int DIV_W  = (G_MCLK_DIV > 1) ? $clog2(G_MCLK_DIV) : 1;
    localparam int BIT_W  = (G_SLOT_BITS > 1) ? $clog2(G_SLOT_BITS) : 1;
    localparam int SLOT_W = (SLOT_N > 1) ? $clog2(SLOT_N) : 1;
    localparam int DATA_W = G_INPUTS * G_BITS;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(G_MCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(G_MCLK_DIV / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(G_SLOT_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_N - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                snap;

    logic [DATA_W-1:0]   pend_left_q, pend_left_d, pend_right_q, pend_right_d;
    logic [DATA_W-1:0]   shad_left_q, shad_left_d, shad_right_q, shad_right_d;
    logic [G_INPUTS-1:0] fresh_q, fresh_d, stale_q, stale_d;

    logic                bclk_q, bclk_d, fsync_q, fsync_d, dout_q, dout_d;
    logic                frame_start_q, frame_start_d, active_q, active_d;
    logic [G_BITS-1:0]   slot_word;

    always_ff @(posedge in_mclk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            slot_q        <= '0;
            pend_left_q   <= '0;
            pend_right_q  <= '0;
            shad_left_q   <= '0;
            shad_right_q  <= '0;
            fresh_q       <= '0;
            stale_q       <= '0;
            bclk_q        <= 1'b0;
            fsync_q       <= 1'b0;
            dout_q        <= 1'b0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            slot_q        <= slot_d;
            pend_left_q   <= pend_left_d;
            pend_right_q  <= pend_right_d;
            shad_left_q   <= shad_left_d;
            shad_right_q  <= shad_right_d;
            fresh_q       <= fresh_d;
            stale_q       <= stale_d;
            bclk_q        <= bclk_d;
            fsync_q       <= fsync_d;
            dout_q        <= dout_d;
            frame_start_q <= frame_start_d;
            active_q      <= active_d;
        end
    end

    // A frame only ends on the very last mclk of slot N-1; enable is sampled there alone.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        slot_d  = slot_q;
        snap    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_enable) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                    bit_d   = '0;
                    slot_d  = '0;
                    snap    = 1'b1;
                end
            end
            ST_RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (slot_q == SLOT_LAST) begin
                            slot_d = '0;
                            if (in_enable) snap = 1'b1;
                            else           state_d = ST_IDLE;
                        end else begin
                            slot_d = slot_q + SLOT_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Snapshot reads the pre-strobe pending/fresh values; a coincident strobe counts next frame.
    always_comb begin
        pend_left_d  = pend_left_q;
        pend_right_d = pend_right_q;
        for (int i = 0; i < G_INPUTS; i++) begin
            if (in_frame_strobe[i]) begin
                pend_left_d[i*G_BITS +: G_BITS]  = in_frame_left[i*G_BITS +: G_BITS];
                pend_right_d[i*G_BITS +: G_BITS] = in_frame_right[i*G_BITS +: G_BITS];
            end
        end
        shad_left_d  = snap ? pend_left_q  : shad_left_q;
        shad_right_d = snap ? pend_right_q : shad_right_q;
        fresh_d      = snap ? in_frame_strobe : (fresh_q | in_frame_strobe);
        stale_d      = (stale_q & ~{G_INPUTS{in_clear_status}}) | (snap ? ~fresh_q : '0);
    end

    // Outputs are registered from next-state values so pins line up with the counters.
    always_comb begin
        slot_word = '0;
        for (int i = 0; i < G_INPUTS; i++) begin
            if (slot_d == SLOT_W'(2 * i))     slot_word = shad_left_d[i*G_BITS +: G_BITS];
            if (slot_d == SLOT_W'(2 * i + 1)) slot_word = shad_right_d[i*G_BITS +: G_BITS];
        end
        dout_d = 1'b0;
        for (int k = 0; k < G_BITS; k++) begin
            if (bit_d == BIT_W'(k)) dout_d = slot_word[G_BITS-1-k];
        end
        active_d      = (state_d == ST_RUN);
        dout_d        = dout_d & active_d;
        bclk_d        = active_d && (div_d >= DIV_HALF);
        fsync_d       = active_d && (bit_d == '0) && (slot_d == '0);
        frame_start_d = snap;
    end

    assign out_bclk        = bclk_q;
    assign out_fsync       = fsync_q;
    assign out_dout        = dout_q;
    assign out_frame_start = frame_start_q;
    assign out_stale       = stale_q;
    assign out_active      = active_q;

endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// Directed bench for tdm_frame_scheduler: per-frame vector table plus reset/enable sequences.
module tb_tdm_frame_scheduler;

    logic        in_mclk;
    logic        in_reset_n;
    logic        in_enable;
    logic [63:0] in_frame_left;
    logic [63:0] in_frame_right;
    logic [3:0]  in_frame_strobe;
    logic        in_clear_status;
    logic        out_bclk, out_fsync, out_dout, out_frame_start, out_active;
    logic [3:0]  out_stale;

    int n_checks = 0;
    int n_fail   = 0;

    tdm_frame_scheduler dut (
        .in_mclk        (in_mclk),
        .in_reset_n     (in_reset_n),
        .in_enable      (in_enable),
        .in_frame_left  (in_frame_left),
        .in_frame_right (in_frame_right),
        .in_frame_strobe(in_frame_strobe),
        .in_clear_status(in_clear_status),
        .out_bclk       (out_bclk),
        .out_fsync      (out_fsync),
        .out_dout       (out_dout),
        .out_frame_start(out_frame_start),
        .out_stale      (out_stale),
        .out_active     (out_active)
    );

    initial begin
        in_mclk = 1'b0;
        forever #5 in_mclk = ~in_mclk;
    end

    // One record per TDM frame: what the frame must carry, and what to drive during it.
    typedef struct packed {
        logic [7:0][15:0] exp_words;
        logic [3:0]       exp_stale;
        int               clr_cyc;
        logic [3:0]       a_mask;
        int               a_cyc;
        logic [3:0][15:0] a_l;
        logic [3:0][15:0] a_r;
        logic [3:0]       b_mask;
        int               b_cyc;
        logic [3:0][15:0] b_l;
        logic [3:0][15:0] b_r;
        int               drop_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge in_mclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t new_vec(input logic [7:0][15:0] w, input logic [3:0] st);
        vec_t v;
        v           = '0;
        v.exp_words = w;
        v.exp_stale = st;
        v.clr_cyc   = -1;
        v.a_cyc     = -1;
        v.b_cyc     = -1;
        v.drop_cyc  = -1;
        return v;
    endfunction

    task automatic apply_strobe(input logic [3:0] m, input logic [3:0][15:0] l,
                                input logic [3:0][15:0] r);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                in_frame_left[i*16 +: 16]  = l[i];
                in_frame_right[i*16 +: 16] = r[i];
            end
        end
        in_frame_strobe = m;
    endtask

    // Entered on the cycle that shows out_frame_start; leaves on the first cycle of the next frame.
    task automatic run_frame(input vec_t v, input int idx);
        logic [31:0] slot_val[8];
        int terr;
        int first_bad;
        terr      = 0;
        first_bad = -1;
        for (int s = 0; s < 8; s++) slot_val[s] = '0;
        for (int c = 0; c < 1024; c++) begin
            int dv;
            int sl;
            logic bad;
            dv  = c % 4;
            sl  = c / 128;
            bad = 1'b0;
            if (c == 0) begin
                check($sformatf("v%0d frame_start", idx), {31'b0, out_frame_start}, 32'd1);
                check($sformatf("v%0d stale", idx), {28'b0, out_stale}, {28'b0, v.exp_stale});
            end else if (out_frame_start !== 1'b0) bad = 1'b1;
            if (out_bclk !== (dv >= 2)) bad = 1'b1;
            if (out_fsync !== (c < 4)) bad = 1'b1;
            if (out_active !== 1'b1) bad = 1'b1;
            if (dv == 0) slot_val[sl] = {slot_val[sl][30:0], out_dout};
            else if (out_dout !== slot_val[sl][0]) bad = 1'b1;
            if (bad) begin
                terr++;
                if (first_bad < 0) first_bad = c;
            end
            in_frame_strobe = '0;
            in_clear_status = 1'b0;
            if (c == v.clr_cyc) in_clear_status = 1'b1;
            if (c == v.a_cyc) apply_strobe(v.a_mask, v.a_l, v.a_r);
            if (c == v.b_cyc) apply_strobe(v.b_mask, v.b_l, v.b_r);
            if (v.drop_cyc >= 0) begin
                if (c == v.drop_cyc)       in_enable = 1'b0;
                if (c == v.drop_cyc + 200) in_enable = 1'b1;
                if (c == v.drop_cyc + 210) in_enable = 1'b0;
            end
            tick();
        end
        in_frame_strobe = '0;
        in_clear_status = 1'b0;
        for (int s = 0; s < 8; s++)
            check($sformatf("v%0d slot%0d", idx, s), slot_val[s], {v.exp_words[s], 16'h0000});
        if (terr != 0) $display("v%0d first timing error at frame cycle %0d", idx, first_bad);
        check($sformatf("v%0d timing_errors", idx), 32'(terr), 32'd0);
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, " bclk"},        {31'b0, out_bclk},        32'd0);
        check({tag, " fsync"},       {31'b0, out_fsync},       32'd0);
        check({tag, " dout"},        {31'b0, out_dout},        32'd0);
        check({tag, " frame_start"}, {31'b0, out_frame_start}, 32'd0);
        check({tag, " active"},      {31'b0, out_active},      32'd0);
    endtask

    initial begin
        in_reset_n      = 1'b0;
        in_enable       = 1'b0;
        in_frame_left   = '0;
        in_frame_right  = '0;
        in_frame_strobe = '0;
        in_clear_status = 1'b0;

        vecs[0] = new_vec({16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'hA5A5}, 4'b1110);
        vecs[0].clr_cyc = 10;
        vecs[0].a_cyc = 200; vecs[0].a_mask = 4'b1111;
        vecs[0].a_l = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        vecs[0].a_r = {16'h8888, 16'h7777, 16'h6666, 16'h5555};

        vecs[1] = new_vec({16'h8888, 16'h4444, 16'h7777, 16'h3333,
                           16'h6666, 16'h2222, 16'h5555, 16'h1111}, 4'b0000);
        vecs[1].a_cyc = 300; vecs[1].a_mask = 4'b0111;
        vecs[1].a_l = {16'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        vecs[1].a_r = {16'h0, 16'hF00F, 16'hEEEE, 16'hDDDD};

        vecs[2] = new_vec({16'h8888, 16'h4444, 16'hF00F, 16'hCCCC,
                           16'hEEEE, 16'hBBBB, 16'hDDDD, 16'hAAAA}, 4'b1000);
        vecs[2].clr_cyc = 1023;
        vecs[2].a_cyc = 500; vecs[2].a_mask = 4'b0111;
        vecs[2].a_l = {16'h0, 16'h0303, 16'h0202, 16'h0101};
        vecs[2].a_r = {16'h0, 16'h0606, 16'h0505, 16'h0404};

        vecs[3] = new_vec({16'h8888, 16'h4444, 16'h0606, 16'h0303,
                           16'h0505, 16'h0202, 16'h0404, 16'h0101}, 4'b1000);
        vecs[3].clr_cyc = 20;
        vecs[3].a_cyc = 300; vecs[3].a_mask = 4'b1101;
        vecs[3].a_l = {16'h4A4A, 16'h3A3A, 16'h0, 16'h1A1A};
        vecs[3].a_r = {16'h4B4B, 16'h3B3B, 16'h0, 16'h1B1B};
        vecs[3].b_cyc = 1023; vecs[3].b_mask = 4'b0010;
        vecs[3].b_l = {16'h0, 16'h0, 16'h0F0F, 16'h0};
        vecs[3].b_r = {16'h0, 16'h0, 16'h0E0E, 16'h0};

        vecs[4] = new_vec({16'h4B4B, 16'h4A4A, 16'h3B3B, 16'h3A3A,
                           16'h0505, 16'h0202, 16'h1B1B, 16'h1A1A}, 4'b0010);
        vecs[4].clr_cyc = 10;
        vecs[4].a_cyc = 100; vecs[4].a_mask = 4'b1101;
        vecs[4].a_l = {16'h4C4C, 16'h3C3C, 16'h0, 16'h1C1C};
        vecs[4].a_r = {16'h4D4D, 16'h3D3D, 16'h0, 16'h1D1D};
        vecs[4].b_cyc = 900; vecs[4].b_mask = 4'b0001;
        vecs[4].b_l = {16'h0, 16'h0, 16'h0, 16'h9999};
        vecs[4].b_r = {16'h0, 16'h0, 16'h0, 16'h8888};

        vecs[5] = new_vec({16'h4D4D, 16'h4C4C, 16'h3D3D, 16'h3C3C,
                           16'h0E0E, 16'h0F0F, 16'h8888, 16'h9999}, 4'b0000);

        vecs[6] = vecs[5];
        vecs[6].exp_stale = 4'b1111;
        vecs[6].drop_cyc  = 3 * 128 + 10;

        repeat (3) tick();
        check_idle_pins("reset");
        check("reset stale", {28'b0, out_stale}, 32'd0);
        @(negedge in_mclk);
        in_reset_n = 1'b1;
        tick();

        apply_strobe(4'b0001, {16'h0, 16'h0, 16'h0, 16'hA5A5}, {16'h0, 16'h0, 16'h0, 16'h1234});
        tick();
        in_frame_strobe = '0;
        repeat (3) tick();
        check("idle active", {31'b0, out_active}, 32'd0);
        in_enable = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

        check_idle_pins("after_drop");
        repeat (5) tick();
        check("idle hold active", {31'b0, out_active}, 32'd0);

        in_enable = 1'b1;
        tick();
        check("reenable frame_start", {31'b0, out_frame_start}, 32'd1);
        check("reenable fsync",       {31'b0, out_fsync},       32'd1);
        check("reenable active",      {31'b0, out_active},      32'd1);

        repeat (5 * 128) tick();
        #2;
        in_reset_n = 1'b0;
        #1;
        check_idle_pins("async_reset");
        check("async_reset stale", {28'b0, out_stale}, 32'd0);
        @(negedge in_mclk);
        in_reset_n = 1'b1;
        tick();
        run_frame(new_vec('0, 4'b1111), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
